// File: rtl/axist_patchkr_mc.sv
// axist_patchkr_mc: multi-segment AXI-ST pattern checker with segment packing, saturating error count and first-error capture
module axist_patchkr_mc #(
  parameter int CHNL_NUM = 2,
  parameter int SEG_WIDTH = 256,
  parameter int CNT_WIDTH = 16,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          chk_en,
  input  logic [1:0]                    pat_sel,
  input  logic [31:0]                   pat_seed,
  input  logic [CNT_WIDTH-1:0]          beat_cnt,
  input  logic                          axist_tvalid,
  output logic                          axist_tready,
  input  logic [CHNL_NUM*SEG_WIDTH-1:0] axist_tdata,
  input  logic [CHNL_NUM-1:0]           axist_denable,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt,
  output logic [CNT_WIDTH-1:0]          first_err_beat,
  output logic [CHNL_NUM-1:0]           first_err_mask,
  output logic [SEG_WIDTH-1:0]          first_err_data,
  output logic                          first_err_vld
);
  localparam int WPS = SEG_WIDTH / 32;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t                 r_state;
  logic                   r_busy, r_done, r_pass, r_fvld;
  logic [1:0]             r_sel;
  logic [31:0]            r_seed, r_ptr;
  logic [CNT_WIDTH-1:0]   r_target, r_cnt, r_fbeat;
  logic [ERR_CNT_WIDTH-1:0] r_err;
  logic [CHNL_NUM-1:0]    r_fmask;
  logic [SEG_WIDTH-1:0]   r_fdata;
  logic [31:0]            w_en_cnt, w_mis_cnt, w_k;
  logic [CHNL_NUM-1:0]    w_mis;
  logic [SEG_WIDTH-1:0]   w_seg, w_low;
  logic                   w_got, w_acc;
  logic [32:0]            w_sum;
  logic [ERR_CNT_WIDTH-1:0] w_err_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  always_comb begin
    w_en_cnt = '0;
    w_mis_cnt = '0;
    w_k = '0;
    w_mis = '0;
    w_seg = '0;
    w_low = '0;
    w_got = 1'b0;
    for (int s = 0; s < CHNL_NUM; s++) begin
      for (int j = 0; j < WPS; j++) begin
        w_k = r_ptr + 32'(WPS) * w_en_cnt + 32'(j);
        w_seg[32*j +: 32] = r_sel == 2'd1 ? r_seed :
                            r_sel == 2'd2 ? (((w_k / 32'(WPS)) % 32'd2) != 0 ? ~r_seed : r_seed) :
                            r_seed + w_k;
      end
      w_mis[s] = axist_denable[s] && (axist_tdata[s*SEG_WIDTH +: SEG_WIDTH] != w_seg);
      if (w_mis[s] && !w_got) begin
        w_low = axist_tdata[s*SEG_WIDTH +: SEG_WIDTH];
        w_got = 1'b1;
      end
      w_en_cnt = w_en_cnt + 32'(axist_denable[s]);
      w_mis_cnt = w_mis_cnt + 32'(w_mis[s]);
    end
  end
  assign w_acc = axist_tvalid & r_busy & (|axist_denable);
  assign w_sum = 33'(r_err) + 33'(w_mis_cnt);
  assign w_err_nxt = w_sum > 33'(ERR_MAX) ? ERR_MAX : w_sum[ERR_CNT_WIDTH-1:0];
  assign w_cnt_nxt = r_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fvld <= 1'b0;
      r_sel <= '0;
      r_seed <= '0;
      r_ptr <= '0;
      r_target <= '0;
      r_cnt <= '0;
      r_fbeat <= '0;
      r_err <= '0;
      r_fmask <= '0;
      r_fdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (chk_en) begin
          r_sel <= pat_sel;
          r_seed <= pat_seed;
          r_target <= beat_cnt;
          r_ptr <= '0;
          r_cnt <= '0;
          r_err <= '0;
          r_fvld <= 1'b0;
          r_fbeat <= '0;
          r_fmask <= '0;
          r_fdata <= '0;
          r_state <= beat_cnt == '0 ? S_DONE : S_RUN;
          r_busy <= beat_cnt != '0;
          r_done <= beat_cnt == '0;
          r_pass <= beat_cnt == '0;
        end
        S_RUN: if (!chk_en) begin
          r_state <= S_IDLE;
          r_busy <= 1'b0;
        end else if (w_acc) begin
          r_ptr <= r_ptr + 32'(WPS) * w_en_cnt;
          r_cnt <= w_cnt_nxt;
          r_err <= w_err_nxt;
          if (|w_mis && !r_fvld) begin
            r_fvld <= 1'b1;
            r_fbeat <= r_cnt;
            r_fmask <= w_mis;
            r_fdata <= w_low;
          end
          if (w_cnt_nxt == r_target) begin
            r_state <= S_DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= w_err_nxt == '0;
          end
        end
        S_DONE: if (!chk_en) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign axist_tready = r_busy;
  assign busy = r_busy;
  assign done = r_done;
  assign pass = r_pass;
  assign err_cnt = r_err;
  assign first_err_beat = r_fbeat;
  assign first_err_mask = r_fmask;
  assign first_err_data = r_fdata;
  assign first_err_vld = r_fvld;
endmodule

// File: tb/tb_axist_patchkr_mc.sv
// tb_axist_patchkr_mc: randomized self-checking bench against a word-stream reference model
module tb_axist_patchkr_mc;
  localparam int W = 512;
  logic clk = 1'b0, rst = 1'b1, chk_en = 1'b0, tvalid = 1'b0;
  logic [1:0] pat_sel = '0, den = '0;
  logic [31:0] pat_seed = '0;
  logic [15:0] beat_cnt = '0;
  logic [W-1:0] tdata = '0;
  logic tready, busy, done, pass, fev;
  logic [3:0] err_cnt;
  logic [15:0] feb;
  logic [1:0] fem;
  logic [255:0] fed;
  int n_cmp = 0, n_bad = 0;
  logic [1:0] m_sel;
  logic [31:0] m_seed, m_ptr;
  int m_cnt, m_err, m_fbeat;
  bit m_fvld;
  logic [1:0] m_fmask;
  logic [255:0] m_fdata;

  axist_patchkr_mc #(.CHNL_NUM(2), .SEG_WIDTH(256), .CNT_WIDTH(16), .ERR_CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .pat_sel(pat_sel), .pat_seed(pat_seed),
    .beat_cnt(beat_cnt), .axist_tvalid(tvalid), .axist_tready(tready), .axist_tdata(tdata),
    .axist_denable(den), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_beat(feb), .first_err_mask(fem), .first_err_data(fed), .first_err_vld(fev));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word(input logic [31:0] k);
    if (m_sel == 2'd1) return m_seed;
    if (m_sel == 2'd2) return ((k / 8) % 2) != 0 ? ~m_seed : m_seed;
    return m_seed + k;
  endfunction

  task automatic start(input logic [1:0] sel, input logic [31:0] seed, input int n);
    pat_sel = sel; pat_seed = seed; beat_cnt = 16'(n); chk_en = 1'b1;
    m_sel = sel; m_seed = seed; m_ptr = '0; m_cnt = 0; m_err = 0;
    m_fvld = 0; m_fbeat = 0; m_fmask = '0; m_fdata = '0;
    @(negedge clk);
    pat_sel = 2'($urandom); pat_seed = $urandom; beat_cnt = 16'($urandom);
  endtask

  task automatic stop();
    tvalid = 1'b0; chk_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic beat(input logic [1:0] d_en, input logic [1:0] bad, input bit zero);
    logic [W-1:0] d;
    logic [255:0] e, seg;
    logic [1:0] mis;
    int p, b;
    p = 0; mis = '0; d = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 8; j++) e[32*j +: 32] = word(m_ptr + 32'(8*p + j));
      if (d_en[s]) begin
        seg = zero ? '0 : e;
        if (bad[s]) begin b = $urandom_range(255); seg[b] = ~seg[b]; end
        mis[s] = seg !== e;
        p++;
      end else begin
        for (int j = 0; j < 8; j++) seg[32*j +: 32] = $urandom;
      end
      d[s*256 +: 256] = seg;
    end
    if (d_en != 0) begin
      m_err = m_err + int'(mis[0]) + int'(mis[1]);
      if (m_err > 15) m_err = 15;
      if (mis != 0 && !m_fvld) begin
        m_fvld = 1; m_fbeat = m_cnt; m_fmask = mis;
        m_fdata = mis[0] ? d[255:0] : d[511:256];
      end
      m_cnt++;
      m_ptr = m_ptr + 32'(8*p);
    end
    tdata = d; den = d_en; tvalid = 1'b1;
    for (int i = 0; i < 20 && !tready; i++) @(negedge clk);
    n_cmp++;
    if (tready !== 1'b1) begin n_bad++; $display("FAIL beat_accept tready=%b expected 1", tready); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tready, busy, done, pass, fev} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b expected 00000", {tready, busy, done, pass, fev}); end
    n_cmp++;
    if ({err_cnt, feb, fem} !== 22'b0) begin n_bad++; $display("FAIL reset_fields err=%0d beat=%0d mask=%b expected 0", err_cnt, feb, fem); end
  endtask

  task automatic test_incrementing();
    start(2'd0, 32'd0, 4);
    n_cmp++;
    if ({busy, tready} !== 2'b11) begin n_bad++; $display("FAIL inc_start busy/tready=%b expected 11", {busy, tready}); end
    repeat (4) beat(2'b11, 2'b00, 0);
    tvalid = 1'b0;
    n_cmp++;
    if ({done, pass, tready, busy} !== 4'b1100) begin n_bad++; $display("FAIL inc_end done/pass/tready/busy=%b expected 1100", {done, pass, tready, busy}); end
    n_cmp++;
    if (err_cnt !== 4'd0) begin n_bad++; $display("FAIL inc_err err_cnt=%0d expected 0", err_cnt); end
    stop();
  endtask

  task automatic test_denable();
    start(2'd0, 32'd0, 4);
    beat(2'b01, 2'b00, 0);
    beat(2'b11, 2'b00, 0);
    beat(2'b00, 2'b00, 0);
    beat(2'b10, 2'b00, 0);
    n_cmp++;
    if ({done, busy} !== 2'b01) begin n_bad++; $display("FAIL den_mid done/busy=%b expected 01", {done, busy}); end
    beat(2'b11, 2'b00, 0);
    tvalid = 1'b0;
    n_cmp++;
    if ({done, pass, tready, err_cnt} !== {3'b110, 4'd0}) begin n_bad++; $display("FAIL den_end done/pass/tready=%b err=%0d expected 110 err 0", {done, pass, tready}, err_cnt); end
    stop();
  endtask

  task automatic test_error();
    start(2'd0, 32'd0, 4);
    beat(2'b11, 2'b00, 0);
    beat(2'b11, 2'b00, 0);
    beat(2'b11, 2'b10, 0);
    beat(2'b11, 2'b00, 0);
    tvalid = 1'b0;
    n_cmp++;
    if (err_cnt !== 4'd1) begin n_bad++; $display("FAIL err_cnt got %0d expected 1", err_cnt); end
    n_cmp++;
    if ({fev, feb, fem} !== {1'b1, 16'd2, 2'b10}) begin n_bad++; $display("FAIL err_first vld=%b beat=%0d mask=%b expected 1 2 10", fev, feb, fem); end
    n_cmp++;
    if (fed !== m_fdata) begin n_bad++; $display("FAIL err_data got %h expected %h", fed, m_fdata); end
    n_cmp++;
    if ({done, pass} !== 2'b10) begin n_bad++; $display("FAIL err_done done/pass=%b expected 10", {done, pass}); end
    stop();
  endtask

  task automatic test_saturate();
    start(2'd2, 32'h5555_5555, 10);
    repeat (7) beat(2'b11, 2'b00, 1);
    n_cmp++;
    if (err_cnt !== 4'd14) begin n_bad++; $display("FAIL sat_mid err_cnt=%0d expected 14", err_cnt); end
    repeat (3) beat(2'b11, 2'b00, 1);
    tvalid = 1'b0;
    n_cmp++;
    if (err_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_end err_cnt=%0d expected 15", err_cnt); end
    n_cmp++;
    if ({feb, fem, done, pass} !== {16'd0, 2'b11, 2'b10}) begin n_bad++; $display("FAIL sat_first beat=%0d mask=%b done/pass=%b expected 0 11 10", feb, fem, {done, pass}); end
    stop();
  endtask

  task automatic test_abort();
    start(2'd0, $urandom, 8);
    beat(2'b11, 2'b01, 0);
    beat(2'b11, 2'($urandom), 0);
    stop();
    n_cmp++;
    if ({tready, busy, done} !== 3'b000) begin n_bad++; $display("FAIL abort_flags tready/busy/done=%b expected 000", {tready, busy, done}); end
    n_cmp++;
    if (err_cnt !== 4'(m_err)) begin n_bad++; $display("FAIL abort_err err_cnt=%0d expected %0d", err_cnt, m_err); end
    @(negedge clk);
    start(2'd0, 32'd0, 0);
    n_cmp++;
    if ({done, pass, tready, err_cnt} !== {3'b110, 4'd0}) begin n_bad++; $display("FAIL zero_run done/pass/tready=%b err=%0d expected 110 0", {done, pass, tready}, err_cnt); end
    stop();
  endtask

  task automatic test_rst_mid();
    start(2'($urandom), $urandom, 8);
    repeat (3) beat(2'b11, 2'b11, 0);
    tvalid = 1'b0; chk_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({tready, busy, done, pass, fev, err_cnt, feb, fem} !== 27'b0) begin n_bad++; $display("FAIL rst_mid outputs err=%0d beat=%0d flags=%b expected 0", err_cnt, feb, {tready, busy, done, pass, fev}); end
    n_cmp++;
    if (fed !== 256'b0) begin n_bad++; $display("FAIL rst_mid data got %h expected 0", fed); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(10, 3);
      start(2'($urandom), $urandom, n);
      for (int i = 0; i < 200 && m_cnt < n; i++)
        beat(2'($urandom), ($urandom % 4 == 0) ? 2'($urandom) : 2'b00, 0);
      tvalid = 1'b0;
      n_cmp++;
      if ({done, pass, busy} !== {1'b1, m_err == 0, 1'b0}) begin n_bad++; $display("FAIL rand%0d done/pass/busy=%b expected %b", r, {done, pass, busy}, {1'b1, m_err == 0, 1'b0}); end
      n_cmp++;
      if (err_cnt !== 4'(m_err) || fev !== m_fvld) begin n_bad++; $display("FAIL rand%0d err=%0d vld=%b expected %0d %b", r, err_cnt, fev, m_err, m_fvld); end
      n_cmp++;
      if ({feb, fem} !== {16'(m_fbeat), m_fmask} || fed !== m_fdata) begin n_bad++; $display("FAIL rand%0d first beat=%0d mask=%b data=%h expected %0d %b %h", r, feb, fem, fed, m_fbeat, m_fmask, m_fdata); end
      stop();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_incrementing();
    test_denable();
    test_error();
    test_saturate();
    test_abort();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axist_patchkr_mc.md
# axist_patchkr_mc

Parametrised multi-segment AXI-ST pattern checker for the follower receive path of the AXI-ST-over-AIB examples. It generates the expected stream internally from a seed and compares every accepted beat across `CHNL_NUM` data segments, honouring a per-segment enable that packs the leader stream into whichever follower segments are valid. It counts mismatches, captures the first failure and reports pass/fail to the CSR block. It generalises the fixed two-segment checker to arbitrary segment count and width, and adds segment-packed pattern tracking, saturating error counting and first-error capture.

## Interface
Parameters:
- `CHNL_NUM`, 2: number of data segments per beat (≥1).
- `SEG_WIDTH`, 256: bits per segment; multiple of 32; `WPS = SEG_WIDTH/32` words per segment.
- `CNT_WIDTH`, 16: width of beat target/counter.
- `ERR_CNT_WIDTH`, 16: width of error counter.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  checker clock (follower write clock domain).
- `rst`  in  1  synchronous active-high reset.
- `chk_en`  in  1  level; high starts/holds a run, low aborts/returns to idle.
- `pat_sel`  in  2  0 incrementing, 1 fixed, 2 alternating, 3 treated as 0.
- `pat_seed`  in  32  pattern seed, sampled at start.
- `beat_cnt`  in  CNT_WIDTH  beats to check, sampled at start.
- `axist_tvalid`  in  1  receive valid.
- `axist_tready`  out  1  receive ready (registered).
- `axist_tdata`  in  CHNL_NUM*SEG_WIDTH  receive data; segment s at bits [s*SEG_WIDTH +: SEG_WIDTH].
- `axist_denable`  in  CHNL_NUM  per-segment data enable.
- `busy`  out  1  state is RUN.
- `done`  out  1  run completed.
- `pass`  out  1  done and zero errors.
- `err_cnt`  out  ERR_CNT_WIDTH  saturating mismatched-segment count.
- `first_err_beat`  out  CNT_WIDTH  beat index of first mismatch.
- `first_err_mask`  out  CHNL_NUM  mismatching segments in that beat.
- `first_err_data`  out  SEG_WIDTH  received data of lowest mismatching segment in that beat.
- `first_err_vld`  out  1  first-error fields are valid.

## Operation
- States IDLE, RUN, DONE. Reset: IDLE, all outputs 0.
- IDLE, `chk_en`=1: latch `pat_sel`/`pat_seed`/`beat_cnt`; clear word pointer, beat counter, `err_cnt`, all first-error fields, `done`, `pass`. If `beat_cnt`=0, go to DONE (pass=1); otherwise go to RUN.
- Beat accepted = `axist_tvalid & axist_tready`. A beat with `axist_denable`=0 is accepted, ignored, and not counted.
- Stream model: expected data is a sequence of 32-bit words consumed by enabled segments in ascending segment order. Segment s consumes words `ptr + WPS*P(s)` … `+WPS-1`, where P(s) is the number of enabled segments below s. Word j of a segment occupies bits [32j +: 32].
- Word value for stream index k: pattern 0 gives `seed + k` (mod 2^32); pattern 1 gives `seed`; pattern 2 gives `seed` when (k/WPS) is even and `~seed` when odd.
- After each counted beat: `ptr += WPS*popcount(denable)`, wrapping mod 2^32; beat counter +1.
- Mismatch for segment s: enabled and any bit differs. Disabled segments are never compared.
- `err_cnt` adds popcount(mismatch mask) each beat and saturates at all-ones.
- First beat with a non-zero mismatch mask captures beat index (counter value before increment), mask, and lowest mismatching segment data, and sets `first_err_vld`. These fields are then frozen until the next start.
- RUN: when the counted beat makes the counter equal `beat_cnt`, go to DONE. `chk_en`=0 in RUN aborts to IDLE; results are held and `done` stays 0.
- DONE: `done`=1, `pass`=(`err_cnt`==0). Hold until `chk_en`=0, then go to IDLE with results held. A new start clears them.

## Timing
- `axist_tready` and `busy` are registered and equal (state==RUN): high the cycle after the start edge, low the cycle after the final beat. Exactly `beat_cnt` counted beats are accepted.
- The compare is combinational against the current pointer. `err_cnt`, first-error fields, `done` and `pass` update on the edge that accepts the beat, so they are visible 1 cycle after acceptance. The final `err_cnt` is stable no later than `done`.
- `rst` overrides everything in any state and takes effect at the next edge.
- Back-to-back beats every cycle are supported with no bubbles.

## Test plan
- CHNL_NUM=2, SEG_WIDTH=256, pat 0, seed 0, beat_cnt 4, denable 2'b11, correct data (beat0 words 0..15, beat3 words 48..63) -> done 1 cycle after beat 4, pass=1, err_cnt=0, tready low after exactly 4 beats.
- Same setup with denable alternating 2'b01, 2'b11, 2'b00, 2'b10, 2'b11: seg0 words 0..7; seg0 8..15 and seg1 16..23; the 2'b00 beat is ignored; seg1 24..31; then 32..47 -> pass=1; 4 beats counted.
- Pat 0, beat_cnt 4, bit 0 of seg1 flipped in beat 2 -> err_cnt=1, first_err_beat=2, mask=2'b10, first_err_data=received seg1, pass=0.
- ERR_CNT_WIDTH=4, pat 2, seed 0x5555_5555, 10 beats with both segments all-zero -> err_cnt=15 (saturated), first_err_beat=0, mask=2'b11.
- Abort: chk_en dropped after 2 beats of 8 -> tready=0 next cycle, done=0, err_cnt held. Restart with beat_cnt 0 -> done=1 and pass=1 one cycle later, tready never asserted.
- rst asserted mid-run after 3 beats -> next cycle all outputs 0, state IDLE. A subsequent run restarts the pointer at seed.
